// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source result FIFOs feeding a multi-port register file,
// granting up to WRITE_NUM conflict-free writes per cycle with round-robin priority.
module wb_arbiter #(
    parameter int REG_NUM    = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SRC_NUM    = 6,
    parameter int WRITE_NUM  = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(REG_NUM)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SRC_NUM-1:0]              srcValid,
    input  logic [AW*SRC_NUM-1:0]           srcAddr,
    input  logic [DATA_WIDTH*SRC_NUM-1:0]   srcData,
    output logic [SRC_NUM-1:0]              srcReady,
    output logic [AW*WRITE_NUM-1:0]         writeAddr,
    output logic [WRITE_NUM-1:0]            writeEnable,
    output logic [DATA_WIDTH*WRITE_NUM-1:0] dataInputs,
    output logic                            idle
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int SW  = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;
    localparam int SW1 = SW + 1;

    logic [AW-1:0]         addrMem_q [SRC_NUM][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] dataMem_q [SRC_NUM][FIFO_DEPTH];
    logic [PW-1:0]         rdPtr_q   [SRC_NUM];
    logic [PW-1:0]         wrPtr_q   [SRC_NUM];
    logic [CW-1:0]         count_q   [SRC_NUM];
    logic [SW-1:0]         rrPtr_q, rrPtr_d;

    logic [SRC_NUM-1:0]              push, pop;
    logic [WRITE_NUM-1:0]            writeEnable_q, writeEnable_d;
    logic [AW*WRITE_NUM-1:0]         writeAddr_q, writeAddr_d;
    logic [DATA_WIDTH*WRITE_NUM-1:0] dataInputs_q, dataInputs_d;

    logic [SW1-1:0] scanSum;
    logic [SW-1:0]  scanIdx;
    logic [AW-1:0]  headAddr;
    logic           conflict, placed, allEmpty;

    // Ready looks only at the registered count, so a full FIFO refuses a push even while popping.
    always_comb begin
        srcReady = '0;
        push     = '0;
        allEmpty = 1'b1;
        for (int i = 0; i < SRC_NUM; i++) begin
            srcReady[i] = (count_q[i] != CW'(FIFO_DEPTH));
            push[i]     = srcValid[i] & srcReady[i];
            if (count_q[i] != '0) allEmpty = 1'b0;
        end
    end

    always_comb begin
        pop           = '0;
        writeEnable_d = '0;
        writeAddr_d   = '0;
        dataInputs_d  = '0;
        rrPtr_d       = rrPtr_q;
        scanSum       = '0;
        scanIdx       = '0;
        headAddr      = '0;
        conflict      = 1'b0;
        placed        = 1'b0;
        for (int k = 0; k < SRC_NUM; k++) begin
            scanSum = {1'b0, rrPtr_q} + SW1'(k);
            if (scanSum >= SW1'(SRC_NUM)) scanSum = scanSum - SW1'(SRC_NUM);
            scanIdx  = scanSum[SW-1:0];
            headAddr = addrMem_q[scanIdx][rdPtr_q[scanIdx]];
            if (count_q[scanIdx] != '0) begin
                // Writes to register 0 are dropped without consuming a lane or moving priority.
                if (headAddr == '0) begin
                    pop[scanIdx] = 1'b1;
                end else begin
                    conflict = 1'b0;
                    placed   = 1'b0;
                    for (int j = 0; j < WRITE_NUM; j++) begin
                        if (writeEnable_d[j] && (writeAddr_d[AW*j +: AW] == headAddr)) conflict = 1'b1;
                    end
                    for (int j = 0; j < WRITE_NUM; j++) begin
                        if (!conflict && !placed && !writeEnable_d[j]) begin
                            writeEnable_d[j]                      = 1'b1;
                            writeAddr_d[AW*j +: AW]               = headAddr;
                            dataInputs_d[DATA_WIDTH*j +: DATA_WIDTH] = dataMem_q[scanIdx][rdPtr_q[scanIdx]];
                            placed                                = 1'b1;
                        end
                    end
                    if (placed) begin
                        pop[scanIdx] = 1'b1;
                        rrPtr_d      = (scanIdx == SW'(SRC_NUM - 1)) ? '0 : scanIdx + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SRC_NUM; i++) begin
                rdPtr_q[i] <= '0;
                wrPtr_q[i] <= '0;
                count_q[i] <= '0;
            end
            rrPtr_q       <= '0;
            writeEnable_q <= '0;
            writeAddr_q   <= '0;
            dataInputs_q  <= '0;
        end else begin
            for (int i = 0; i < SRC_NUM; i++) begin
                if (push[i]) wrPtr_q[i] <= wrPtr_q[i] + 1'b1;
                if (pop[i])  rdPtr_q[i] <= rdPtr_q[i] + 1'b1;
                if (push[i] && !pop[i])      count_q[i] <= count_q[i] + 1'b1;
                else if (pop[i] && !push[i]) count_q[i] <= count_q[i] - 1'b1;
            end
            rrPtr_q       <= rrPtr_d;
            writeEnable_q <= writeEnable_d;
            writeAddr_q   <= writeAddr_d;
            dataInputs_q  <= dataInputs_d;
        end
    end

    // Storage needs no reset: reset empties the FIFOs, so stale slots are never read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < SRC_NUM; i++) begin
            if (push[i]) begin
                addrMem_q[i][wrPtr_q[i]] <= srcAddr[AW*i +: AW];
                dataMem_q[i][wrPtr_q[i]] <= srcData[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    assign writeEnable = writeEnable_q;
    assign writeAddr   = writeAddr_q;
    assign dataInputs  = dataInputs_q;
    assign idle        = allEmpty && (writeEnable_q == '0);

endmodule
